decode_stage: RTL and testbench

- Pipeline stage between instruction fetch and the immediate unit / execute stage.
- Accepts 32-bit instruction words with a PC from fetch over a valid/ready handshake.
- Buffers them in a 2-entry skid buffer.
- Presents a decoded bundle downstream: opcode class, immediate select, register indices, funct fields, and instruction bits [31:7] for the immediate unit.
- Sustains one instruction per cycle, supports stall, and supports flush on branch redirect.

---
 rtl/decode_stage_pkg.sv | 32 +++
 rtl/decode_opcode.sv | 49 ++++
 rtl/decode_stage.sv | 195 +++++++++++++++++++
 tb/tb_decode_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: immediate selects, RV32I opcodes, buffer states.
// Imported by decode_opcode and decode_stage.
package decode_stage_pkg;

    localparam int IMM_SEL_WIDTH = 2;

    localparam logic [IMM_SEL_WIDTH:0] IMM_UNKNOWN_TYPE = 3'd0;
    localparam logic [IMM_SEL_WIDTH:0] IMM_I_TYPE       = 3'd1;
    localparam logic [IMM_SEL_WIDTH:0] IMM_S_TYPE       = 3'd2;
    localparam logic [IMM_SEL_WIDTH:0] IMM_B_TYPE       = 3'd3;
    localparam logic [IMM_SEL_WIDTH:0] IMM_U_TYPE       = 3'd4;
    localparam logic [IMM_SEL_WIDTH:0] IMM_J_TYPE       = 3'd5;

    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/decode_opcode.sv
// Combinational opcode classifier: immediate select and, optionally, legality.
// The o_Legal port exists only when DECODE_ILLEGAL_TRAP_EN is defined.
module decode_opcode
    import decode_stage_pkg::*;
(
    input  logic [6:0]               i_Opcode,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                     o_Legal,
`endif
    output logic [IMM_SEL_WIDTH:0]   o_Imm_Select
);

    logic w_IsU;
    logic w_IsJ;
    logic w_IsI;
    logic w_IsS;
    logic w_IsB;

    assign w_IsU = (i_Opcode == OPCODE_LUI) ||
                   (i_Opcode == OPCODE_AUIPC);
    assign w_IsJ = (i_Opcode == OPCODE_JAL);
    assign w_IsI = (i_Opcode == OPCODE_JALR)   ||
                   (i_Opcode == OPCODE_LOAD)   ||
                   (i_Opcode == OPCODE_OP_IMM) ||
                   (i_Opcode == OPCODE_SYSTEM) ||
                   (i_Opcode == OPCODE_MISC_MEM);
    assign w_IsS = (i_Opcode == OPCODE_STORE);
    assign w_IsB = (i_Opcode == OPCODE_BRANCH);

    // Map the opcode class onto the immediate format; R-type and unknowns share UNKNOWN
    always_comb begin
        o_Imm_Select = IMM_UNKNOWN_TYPE;
        unique case (1'b1)
            w_IsU:   o_Imm_Select = IMM_U_TYPE;
            w_IsJ:   o_Imm_Select = IMM_J_TYPE;
            w_IsI:   o_Imm_Select = IMM_I_TYPE;
            w_IsS:   o_Imm_Select = IMM_S_TYPE;
            w_IsB:   o_Imm_Select = IMM_B_TYPE;
            default: o_Imm_Select = IMM_UNKNOWN_TYPE;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Every mapped opcode ends in 2'b11, so list membership covers the low-bit rule too
    assign o_Legal = w_IsU | w_IsJ | w_IsI | w_IsS | w_IsB |
                     (i_Opcode == OPCODE_OP);
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode stage: 2-entry skid buffer with decode registered at capture.
// Optional o_Illegal tracking under DECODE_ILLEGAL_TRAP_EN.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     i_Flush,
    input  logic                     i_Valid,
    output logic                     o_Ready,
    input  logic [XLEN-1:0]          i_Instruction,
    input  logic [XLEN-1:0]          i_PC,
    output logic                     o_Valid,
    input  logic                     i_Ready,
    output logic [XLEN-1:0]          o_PC,
    output logic [XLEN-1:7]          o_Instruction_No_Opcode,
    output logic [IMM_SEL_WIDTH:0]   o_Imm_Select,
    output logic [4:0]               o_Rs1,
    output logic [4:0]               o_Rs2,
    output logic [4:0]               o_Rd,
    output logic [2:0]               o_Funct3,
    output logic [6:0]               o_Funct7,
    output logic [6:0]               o_Opcode,
    output logic                     o_Illegal
);

    buf_state_t              r_State;
    logic                    r_Valid;
    logic                    r_Ready;

    logic [XLEN-1:0]         r_HeadPC;
    logic [XLEN-1:0]         r_HeadInstr;
    logic [IMM_SEL_WIDTH:0]  r_HeadImmSel;
    logic [XLEN-1:0]         r_SkidPC;
    logic [XLEN-1:0]         r_SkidInstr;
    logic [IMM_SEL_WIDTH:0]  r_SkidImmSel;

    logic                    w_InFire;
    logic                    w_OutFire;
    logic                    w_LoadHead;
    logic                    w_LoadSkid;
    logic                    w_SkidToHead;
    logic [IMM_SEL_WIDTH:0]  w_ImmSel;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                    w_Legal;
    logic                    r_HeadIllegal;
    logic                    r_SkidIllegal;
`endif

    assign w_InFire  = i_Valid & r_Ready;
    assign w_OutFire = r_Valid & i_Ready;

    decode_opcode u_decode_opcode (
        .i_Opcode     (i_Instruction[6:0]),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .o_Legal      (w_Legal),
`endif
        .o_Imm_Select (w_ImmSel)
    );

    // Select which buffer slot moves this cycle, from the current state and fires
    always_comb begin
        w_LoadHead   = 1'b0;
        w_LoadSkid   = 1'b0;
        w_SkidToHead = 1'b0;
        unique case (r_State)
            ST_EMPTY: w_LoadHead = w_InFire;
            ST_ONE: begin
                w_LoadHead = w_InFire & w_OutFire;
                w_LoadSkid = w_InFire & ~w_OutFire;
            end
            ST_TWO:   w_SkidToHead = w_OutFire;
            default: begin
                w_LoadHead   = 1'b0;
                w_LoadSkid   = 1'b0;
                w_SkidToHead = 1'b0;
            end
        endcase
    end

    // Occupancy FSM; valid/ready are registered from the next state
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State <= ST_EMPTY;
            r_Valid <= 1'b0;
            r_Ready <= 1'b0;
        end else if (i_Flush) begin
            r_State <= ST_EMPTY;
            r_Valid <= 1'b0;
            r_Ready <= 1'b1;
        end else begin
            unique case (r_State)
                ST_EMPTY: begin
                    r_Ready <= 1'b1;
                    if (w_InFire) begin
                        r_State <= ST_ONE;
                        r_Valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_InFire && !w_OutFire) begin
                        r_State <= ST_TWO;
                        r_Valid <= 1'b1;
                        r_Ready <= 1'b0;
                    end else if (w_OutFire && !w_InFire) begin
                        r_State <= ST_EMPTY;
                        r_Valid <= 1'b0;
                        r_Ready <= 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_OutFire) begin
                        r_State <= ST_ONE;
                        r_Valid <= 1'b1;
                        r_Ready <= 1'b1;
                    end
                end
                default: begin
                    r_State <= ST_EMPTY;
                    r_Valid <= 1'b0;
                    r_Ready <= 1'b1;
                end
            endcase
        end
    end

    // Head entry: loaded from the input or promoted from the skid slot
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_HeadPC     <= '0;
            r_HeadInstr  <= '0;
            r_HeadImmSel <= IMM_UNKNOWN_TYPE;
        end else if (w_LoadHead) begin
            r_HeadPC     <= i_PC;
            r_HeadInstr  <= i_Instruction;
            r_HeadImmSel <= w_ImmSel;
        end else if (w_SkidToHead) begin
            r_HeadPC     <= r_SkidPC;
            r_HeadInstr  <= r_SkidInstr;
            r_HeadImmSel <= r_SkidImmSel;
        end
    end

    // Skid entry: absorbs the one instruction that arrives while the head stalls
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_SkidPC     <= '0;
            r_SkidInstr  <= '0;
            r_SkidImmSel <= IMM_UNKNOWN_TYPE;
        end else if (w_LoadSkid) begin
            r_SkidPC     <= i_PC;
            r_SkidInstr  <= i_Instruction;
            r_SkidImmSel <= w_ImmSel;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Illegal flag travels with its entry through both slots
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_HeadIllegal <= 1'b0;
            r_SkidIllegal <= 1'b0;
        end else begin
            if (w_LoadHead) begin
                r_HeadIllegal <= ~w_Legal;
            end else if (w_SkidToHead) begin
                r_HeadIllegal <= r_SkidIllegal;
            end
            if (w_LoadSkid) begin
                r_SkidIllegal <= ~w_Legal;
            end
        end
    end

    assign o_Illegal = r_HeadIllegal;
`else
    assign o_Illegal = 1'b0;
`endif

    assign o_Valid                 = r_Valid;
    assign o_Ready                 = r_Ready;
    assign o_PC                    = r_HeadPC;
    assign o_Instruction_No_Opcode = r_HeadInstr[XLEN-1:7];
    assign o_Imm_Select            = r_HeadImmSel;
    assign o_Rd                    = r_HeadInstr[11:7];
    assign o_Funct3                = r_HeadInstr[14:12];
    assign o_Rs1                   = r_HeadInstr[19:15];
    assign o_Rs2                   = r_HeadInstr[24:20];
    assign o_Funct7                = r_HeadInstr[31:25];
    assign o_Opcode                = r_HeadInstr[6:0];

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random traffic
// checked against a queue-based model of the stage.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic                    i_Clock = 1'b0;
    logic                    i_Reset;
    logic                    i_Flush;
    logic                    i_Valid;
    logic                    o_Ready;
    logic [31:0]             i_Instruction;
    logic [31:0]             i_PC;
    logic                    o_Valid;
    logic                    i_Ready;
    logic [31:0]             o_PC;
    logic [31:7]             o_Instruction_No_Opcode;
    logic [IMM_SEL_WIDTH:0]  o_Imm_Select;
    logic [4:0]              o_Rs1;
    logic [4:0]              o_Rs2;
    logic [4:0]              o_Rd;
    logic [2:0]              o_Funct3;
    logic [6:0]              o_Funct7;
    logic [6:0]              o_Opcode;
    logic                    o_Illegal;

    decode_stage #(.XLEN(32)) dut (
        .i_Clock                 (i_Clock),
        .i_Reset                 (i_Reset),
        .i_Flush                 (i_Flush),
        .i_Valid                 (i_Valid),
        .o_Ready                 (o_Ready),
        .i_Instruction           (i_Instruction),
        .i_PC                    (i_PC),
        .o_Valid                 (o_Valid),
        .i_Ready                 (i_Ready),
        .o_PC                    (o_PC),
        .o_Instruction_No_Opcode (o_Instruction_No_Opcode),
        .o_Imm_Select            (o_Imm_Select),
        .o_Rs1                   (o_Rs1),
        .o_Rs2                   (o_Rs2),
        .o_Rd                    (o_Rd),
        .o_Funct3                (o_Funct3),
        .o_Funct7                (o_Funct7),
        .o_Opcode                (o_Opcode),
        .o_Illegal               (o_Illegal)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [IMM_SEL_WIDTH:0] ref_sel(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110111, 7'b0010111: return IMM_U_TYPE;
            7'b1101111:             return IMM_J_TYPE;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b1110011, 7'b0001111: return IMM_I_TYPE;
            7'b0100011:             return IMM_S_TYPE;
            7'b1100011:             return IMM_B_TYPE;
            default:                return IMM_UNKNOWN_TYPE;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [31:0] ins);
`ifdef DECODE_ILLEGAL_TRAP_EN
        return (ref_sel(ins) == IMM_UNKNOWN_TYPE) && (ins[6:0] != 7'b0110011);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs();
        ent_t e;
        chk("valid", 32'(o_Valid), 32'(q.size() > 0));
        chk("ready", 32'(o_Ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            chk("pc", o_PC, e.pc);
            chk("no_opc", 32'(o_Instruction_No_Opcode), 32'(e.ins >> 7));
            chk("immsel", 32'(o_Imm_Select), 32'(ref_sel(e.ins)));
            chk("rd", 32'(o_Rd), 32'(e.ins[11:7]));
            chk("f3", 32'(o_Funct3), 32'(e.ins[14:12]));
            chk("rs1", 32'(o_Rs1), 32'(e.ins[19:15]));
            chk("rs2", 32'(o_Rs2), 32'(e.ins[24:20]));
            chk("f7", 32'(o_Funct7), 32'(e.ins[31:25]));
            chk("opc", 32'(o_Opcode), 32'(e.ins[6:0]));
            chk("illegal", 32'(o_Illegal), 32'(ref_ill(e.ins)));
        end
    endtask

    // One cycle: check at negedge, drive, advance model, wait for posedge
    task automatic step(input bit v, input logic [31:0] ins,
                        input logic [31:0] pc, input bit rdy, input bit fl);
        bit in_f;
        bit out_f;
        ent_t e;
        @(negedge i_Clock);
        check_outputs();
        i_Valid = v;
        i_Instruction = ins;
        i_PC = pc;
        i_Ready = rdy;
        i_Flush = fl;
        in_f  = v && (q.size() < 2);
        out_f = rdy && (q.size() > 0);
        if (fl) begin
            q.delete();
        end else begin
            if (out_f) void'(q.pop_front());
            if (in_f) begin
                e.pc = pc;
                e.ins = ins;
                q.push_back(e);
            end
        end
        @(posedge i_Clock);
    endtask

    task automatic do_reset();
        i_Valid = 1'b0;
        i_Flush = 1'b0;
        i_Ready = 1'b0;
        i_Reset = 1'b1;
        q.delete();
        repeat (2) @(posedge i_Clock);
        #1;
        chk("rst_valid", 32'(o_Valid), 32'd0);
        chk("rst_ready", 32'(o_Ready), 32'd0);
        chk("rst_immsel", 32'(o_Imm_Select), 32'(IMM_UNKNOWN_TYPE));
        chk("rst_pc", o_PC, 32'd0);
        @(negedge i_Clock);
        i_Reset = 1'b0;
        @(posedge i_Clock);
    endtask

    bit [6:0] ops [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                           7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                           7'b0110011, 7'b1110011, 7'b0001111, 7'b1010101};

    initial begin
        logic [31:0] ins;
        i_Instruction = '0;
        i_PC = '0;
        do_reset();

        // LUI with immediate acceptance
        step(1, 32'h12345037, 32'h0000_1000, 1, 0);
        #1;
        chk("lui_valid", 32'(o_Valid), 32'd1);
        chk("lui_sel", 32'(o_Imm_Select), 32'(IMM_U_TYPE));
        chk("lui_rd", 32'(o_Rd), 32'd0);
        chk("lui_opc", 32'(o_Opcode), 32'h37);
        chk("lui_noopc", 32'(o_Instruction_No_Opcode), 32'h12345037 >> 7);

        // Back-to-back stream
        step(1, 32'h00A00093, 32'h1004, 1, 0);
        #1 chk("b2b_sel_i", 32'(o_Imm_Select), 32'(IMM_I_TYPE));
        step(1, 32'hFE209EE3, 32'h1008, 1, 0);
        #1 chk("b2b_sel_b", 32'(o_Imm_Select), 32'(IMM_B_TYPE));
        step(1, 32'h00112223, 32'h100C, 1, 0);
        #1 chk("b2b_sel_s", 32'(o_Imm_Select), 32'(IMM_S_TYPE));
        step(0, 32'h0, 32'h0, 1, 0);

        // Stall with three offers
        step(1, 32'h00100113, 32'h2000, 0, 0);
        step(1, 32'h00200193, 32'h2004, 0, 0);
        #1 chk("stall_ready", 32'(o_Ready), 32'd0);
        step(1, 32'h00300213, 32'h2008, 0, 0);
        step(1, 32'h00300213, 32'h2008, 0, 0);
        #1 chk("stall_head", o_PC, 32'h2000);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(1, 32'h00300213, 32'h2008, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Flush in TWO with a same-cycle offer
        step(1, 32'h00400293, 32'h3000, 0, 0);
        step(1, 32'h00500313, 32'h3004, 0, 0);
        step(1, 32'h00600393, 32'h3008, 0, 1);
        #1;
        chk("flush_valid", 32'(o_Valid), 32'd0);
        chk("flush_ready", 32'(o_Ready), 32'd1);
        i_Flush = 1'b0;

        // Illegal (all-zero) instruction
        step(1, 32'h00000000, 32'h4000, 0, 0);
        #1;
        chk("zero_sel", 32'(o_Imm_Select), 32'(IMM_UNKNOWN_TYPE));
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("zero_ill", 32'(o_Illegal), 32'd1);
`else
        chk("zero_ill", 32'(o_Illegal), 32'd0);
`endif
        step(0, 32'h0, 32'h0, 1, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 7) != 0)
                ins[6:0] = ops[$urandom_range(0, 11)];
            step(bit'($urandom_range(0, 3) != 0), ins, $urandom,
                 bit'($urandom_range(0, 2) != 0),
                 bit'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset between edges
        step(1, 32'h00700413, 32'h5000, 0, 0);
        step(1, 32'h00800493, 32'h5004, 0, 0);
        #2 i_Reset = 1'b1;
        #1;
        chk("areset_valid", 32'(o_Valid), 32'd0);
        chk("areset_ready", 32'(o_Ready), 32'd0);
        chk("areset_pc", o_PC, 32'd0);
        chk("areset_sel", 32'(o_Imm_Select), 32'(IMM_UNKNOWN_TYPE));
        q.delete();
        i_Valid = 1'b0;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        @(posedge i_Clock);
        #1 chk("post_rst_ready", 32'(o_Ready), 32'd1);
        step(1, 32'h00900513, 32'h6000, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
